mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port memory between an instruction-fetch requester (IF)
//   and a data-memory requester (DM). Data requests normally win, but a fetch
//   that has been passed over STARVE_LIMIT times in a row is granted next.
//   Each transaction runs GNT_x -> RESP -> IDLE. A memory that never answers
//   is abandoned after TIMEOUT cycles and the ack is flagged with err.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   if_req/if_addr    : fetch read request (held until if_ack)
//   if_rdata/if_ack   : registered fetch data, one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata : data request (held until dm_ack)
//   dm_rdata/dm_ack   : registered read data, one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata : registered request to the memory
//   mem_rdata/mem_ready : memory read data and one-cycle completion
//   err               : pulses together with the ack of a timed-out access
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  // The grant cycle in which the counter holds this value is the last one.
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM, RESP} state_t;

  state_t                  state_q;
  logic [SW-1:0]           starve_q;
  logic [WW-1:0]           wait_q;
  logic                    mem_req_q;
  logic                    mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [DATA_WIDTH-1:0]   if_rdata_q;
  logic [DATA_WIDTH-1:0]   dm_rdata_q;
  logic                    if_ack_q;
  logic                    dm_ack_q;
  logic                    err_q;

  logic                    pick_dm_d;
  logic [SW-1:0]           starve_d;
  logic [WW-1:0]           wait_d;
  logic                    timeout_d;

  // Arbitration decision and starvation bookkeeping, only used from IDLE.
  always_comb begin
    pick_dm_d = dm_req && ((starve_q < STARVE_MAX) || !if_req);
    starve_d  = starve_q;
    if (pick_dm_d) begin
      // Only a data grant that actually passes over a waiting fetch counts.
      if (if_req && (starve_q != STARVE_MAX)) begin
        starve_d = starve_q + SW'(1);
      end
    end else if (if_req) begin
      starve_d = '0;
    end
    wait_d    = wait_q + WW'(1);
    timeout_d = (wait_q == WAIT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      wait_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Acks and err are single-cycle pulses raised only on entry to RESP.
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          wait_q   <= '0;
          starve_q <= starve_d;
          if (pick_dm_d) begin
            state_q     <= GNT_DM;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_we;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
          end else if (if_req) begin
            state_q     <= GNT_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
          end
        end
        GNT_IF: begin
          // A ready on the final wait cycle still counts as a normal completion.
          if (mem_ready || timeout_d) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            if_ack_q  <= 1'b1;
            err_q     <= !mem_ready;
            if (mem_ready) begin
              if_rdata_q <= mem_rdata;
            end
          end else begin
            wait_q <= wait_d;
          end
        end
        GNT_DM: begin
          if (mem_ready || timeout_d) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            dm_ack_q  <= 1'b1;
            err_q     <= !mem_ready;
            if (mem_ready && !mem_we_q) begin
              dm_rdata_q <= mem_rdata;
            end
          end else begin
            wait_q <= wait_d;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign err       = err_q;

endmodule
